move_serializer: RTL and testbench
==================================

Name: move_serializer

Overview:
- Upstream feeder for the chess move-recognition FSM, which consumes a single-bit serial stream `x`.
- Accepts parallel move codes through a valid/ready handshake and buffers them in a small FIFO.
- Emits each code as a framed serial bit stream on `x`, one bit per CLK, so the downstream FSM sees deterministic timing.

Parameters:
- W, 6, move code width in bits (W >= 1).
- GAP, 2, idle zero cycles after each frame's last data bit (GAP >= 0).
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- CLK  input  1  system clock, rising edge active.
- RESET  input  1  asynchronous, active-high reset.
- move_in  input  W  move code presented by the producer.
- move_valid  input  1  move_in is valid this cycle.
- move_ready  output  1  FIFO can accept; combinational `!full`.
- x  output  1  registered serial stream to the downstream FSM.
- frame_start  output  1  registered; high exactly in the cycle x carries a start bit.
- busy  output  1  high whenever state != IDLE.
- frames_sent  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET is asynchronous and active-high.
- Reset values:
  - FIFO empty, so move_ready = 1.
  - x = 0, frame_start = 0, busy = 0, frames_sent = 0.
  - State IDLE, bit counter 0, gap counter 0.
- Push: occurs on a rising edge where move_valid && move_ready. The pushing producer holds nothing; a valid while move_ready = 0 is dropped with no side effect.
- FIFO rules:
  - Standard circular FIFO; pointers wrap modulo DEPTH.
  - Push and pop on the same edge are both performed; the count is unchanged.
  - move_ready falls in the cycle after the edge that makes the count reach DEPTH.
- Frame format: start bit 1, then W data bits MSB first, then GAP bits of 0. Frame period is 1+W+GAP cycles.
- States: IDLE, SHIFT, GAP.
  - IDLE:
    - x = 0.
    - On an edge with FIFO non-empty: pop the head into the shift register, x <= 1, frame_start <= 1, bit_cnt <= W-1, go to SHIFT.
    - An entry pushed on edge k is popped no earlier than edge k+1, so there is no bypass.
  - SHIFT:
    - Each edge: x <= sreg[bit_cnt], frame_start <= 0, decrement bit_cnt.
    - After the edge that drives bit 0: if GAP > 0, go to GAP with gap_cnt = GAP; otherwise apply the end-of-frame rule.
  - GAP: each edge x <= 0; gap_cnt decrements. When the last gap cycle completes, apply the end-of-frame rule.
  - End-of-frame rule:
    - frames_sent increments on the edge that leaves the frame.
    - If the FIFO is non-empty, pop and drive the next start bit on that same edge, with no IDLE cycle.
    - If the FIFO is empty, go to IDLE with x <= 0.
- busy follows state; it is 0 only in IDLE.
- An all-zero code is legal. The start bit alone distinguishes the frame from idle.
- RESET asserted mid-frame: immediate abort, x = 0, queued entries discarded, the partial frame is not counted.
- The frames_sent increment and a wrap on the same edge behave normally: 255 -> 0.

Test Plan:
- Reset check: RESET=1 for 5 cycles, then released → x=0, busy=0, move_ready=1, frames_sent=0, frame_start=0.
- Single frame: push move_in=6'b101101 at edge k.
  - From edge k+1, x reads 1,1,0,1,1,0,1,0,0.
  - frame_start high only in cycle k+1.
  - busy high for 9 cycles.
  - frames_sent=1 after edge k+9, then x=0 and busy=0.
- Back-to-back and full: push codes 6'h3F,6'h01,6'h2A,6'h15,6'h00 on consecutive edges k..k+4.
  - move_ready=0 after edge k+4; a 6th valid at edge k+5 is dropped.
  - Frames emerge with period 9 and no idle between them; the 6'h00 frame reads 1,0,0,0,0,0,0,0,0.
  - frames_sent=5 at the end.
- Simultaneous push/pop: with count=2, push on the same edge as a frame-boundary pop → count stays 2, move_ready stays 1.
- Reset mid-frame: assert RESET asynchronously (between edges) during data bit 3 of a frame with 2 entries queued.
  - x=0 immediately.
  - After release: busy=0, move_ready=1, frames_sent unchanged, no frames emitted.
- Wrap: stream 256 frames of 6'h2A → frames_sent returns to 0 after the 256th frame and the x pattern is unbroken.

Source files
------------

// File: rtl/move_serializer.sv
// move_serializer: FIFO-buffered parallel move codes emitted as framed serial bits (start bit, MSB-first data, zero gap).
module move_serializer #(
  parameter int W     = 6,
  parameter int GAP   = 2,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] move_in,
  input  logic         move_valid,
  output logic         move_ready,
  output logic         x,
  output logic         frame_start,
  output logic         busy,
  output logic [7:0]   frames_sent
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          x_q, x_d, fs_q, fs_d;
  logic [7:0]    sent_q, sent_d;
  logic          push, pop, empty, eof;
  assign empty       = cnt_q == '0;
  assign move_ready  = cnt_q != (AW+1)'(DEPTH);
  assign push        = move_valid && move_ready;
  // gap_q reaching zero in S_GAP marks the edge that closes the frame
  assign eof         = state_q == S_GAP && gap_q == '0;
  assign pop         = !empty && (state_q == S_IDLE || eof);
  assign x           = x_q;
  assign frame_start = fs_q;
  assign busy        = state_q != S_IDLE;
  assign frames_sent = sent_q;
  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    x_d     = x_q;
    fs_d    = 1'b0;
    sent_d  = eof ? sent_q + 8'd1 : sent_q;
    if (state_q == S_SHIFT) begin
      x_d   = sreg_q[bit_q];
      bit_d = bit_q - BW'(1);
      if (bit_q == '0) begin
        state_d = S_GAP;
        gap_d   = GW'(GAP);
      end
    end else if (state_q == S_GAP && !eof) begin
      x_d   = 1'b0;
      gap_d = gap_q - GW'(1);
    end
    if (pop) begin
      sreg_d  = mem_q[rptr_q];
      x_d     = 1'b1;
      fs_d    = 1'b1;
      bit_d   = BW'(W - 1);
      state_d = S_SHIFT;
    end else if (state_q == S_IDLE || eof) begin
      x_d     = 1'b0;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= move_in;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      fs_q    <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      fs_q    <= fs_d;
      sent_q  <= sent_d;
    end
  end
endmodule

// File: tb/tb_move_serializer.sv
// tb_move_serializer: directed stimulus with a scoreboard queue of accepted codes checked by a frame monitor.
module tb_move_serializer;
  localparam int W = 6;
  localparam int GAP = 2;
  logic         CLK = 0;
  logic         RESET = 1;
  logic [W-1:0] move_in = '0;
  logic         move_valid = 0;
  logic         move_ready, x, frame_start, busy;
  logic [7:0]   frames_sent;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] q[$];

  move_serializer #(.W(W), .GAP(GAP), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .x(x), .frame_start(frame_start), .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic push_try(input logic [W-1:0] c, output bit acc);
    @(negedge CLK);
    move_in = c;
    move_valid = 1;
    acc = move_ready;
    @(posedge CLK);
    #1 move_valid = 0;
    if (acc) q.push_back(c);
  endtask

  task automatic push(input logic [W-1:0] c, input bit exp_rdy);
    bit acc;
    push_try(c, acc);
    chk("move_ready_at_push", acc, exp_rdy);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge CLK);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1;
    q.delete();
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
  endtask

  int ph = 0, bi = 0, g = 0;
  bit exp_start = 0;
  logic [7:0] done = 0;
  logic [W-1:0] cur = '0;
  always @(negedge CLK) begin
    if (RESET) begin
      ph = 0;
      done = 0;
      exp_start = 0;
    end else if (ph == 0) begin
      if (exp_start) chk("back_to_back", frame_start, 1);
      exp_start = 0;
      chk("frames_sent", frames_sent, done);
      if (frame_start) begin
        chk("frame_expected", q.size() > 0, 1);
        cur = (q.size() > 0) ? q.pop_front() : '0;
        chk("start_bit", x, 1);
        chk("busy_start", busy, 1);
        bi = W - 1;
        ph = 1;
      end else begin
        chk("idle_x", x, 0);
      end
    end else begin
      chk("frame_start_low", frame_start, 0);
      chk("busy_frame", busy, 1);
      if (ph == 1) begin
        chk("data_bit", x, cur[bi]);
        if (bi == 0) begin
          g = GAP;
          ph = 2;
        end else bi--;
      end else begin
        chk("gap_bit", x, 0);
        g--;
      end
      if (ph == 2 && g == 0) begin
        done++;
        exp_start = q.size() > 0;
        ph = 0;
      end
    end
  end

  initial begin
    bit acc;
    bit [8:0] seq;
    int n;
    // reset state
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("rst_x", x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_frames_sent", frames_sent, 0);
    chk("rst_frame_start", frame_start, 0);
    // reset during data bit 3 with two entries queued
    push(6'h15, 1);
    push(6'h0C, 1);
    push(6'h33, 1);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1;
    q.delete();
    #1;
    chk("abort_x", x, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    repeat (20) @(negedge CLK);
    chk("abort_busy_after", busy, 0);
    chk("abort_ready", move_ready, 1);
    chk("abort_frames_sent", frames_sent, 0);
    // single frame, hand-computed bit sequence
    seq = 9'b110110100;
    push(6'b101101, 1);
    @(posedge CLK);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      chk("single_x", x, seq[8-i]);
      chk("single_busy", busy, 1);
      chk("single_fs", frame_start, i == 0);
    end
    @(negedge CLK);
    chk("single_end_x", x, 0);
    chk("single_end_busy", busy, 0);
    chk("single_end_sent", frames_sent, 1);
    // back-to-back until full, sixth valid dropped
    push(6'h3F, 1);
    push(6'h01, 1);
    push(6'h2A, 1);
    push(6'h15, 1);
    push(6'h00, 1);
    push(6'h07, 0);
    wait_idle();
    @(negedge CLK);
    chk("b2b_sent", frames_sent, 6);
    // push on the frame-boundary pop edge with two queued
    push(6'h11, 1);
    push(6'h22, 1);
    push(6'h33, 1);
    repeat (7) @(posedge CLK);
    push(6'h05, 1);
    @(negedge CLK);
    chk("simul_ready", move_ready, 1);
    push(6'h0A, 1);
    push(6'h14, 1);
    push(6'h28, 0);
    wait_idle();
    @(negedge CLK);
    chk("simul_sent", frames_sent, 12);
    // 256 frames wrap the counter back to 0
    do_reset();
    chk("wrap_start_sent", frames_sent, 0);
    n = 0;
    for (int i = 0; i < 5000 && n < 256; i++) begin
      push_try(6'h2A, acc);
      if (acc) n++;
    end
    chk("wrap_pushed", n, 256);
    wait_idle();
    @(negedge CLK);
    chk("wrap_sent", frames_sent, 0);
    chk("wrap_queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
